nx_msg_distributor: RTL

- Sits directly downstream of the message decoder in each node.
- Merges two outbound message streams: the decoder's bypass stream (forwarded or broadcast traffic) and the node's locally emitted stream (signal state updates from node outputs).
- Steers each message into one of four per-direction single-entry holding registers (N/E/S/W) that drive the mesh links.
- Arbitrates fairly when both sources target the same direction in the same cycle.

---
 rtl/nx_msg_distributor_pkg.sv | 14 +
 rtl/nx_msg_dist_slot.sv | 45 ++++
 rtl/nx_msg_distributor.sv | 85 ++++++++
 3 files changed

// File: rtl/nx_msg_distributor_pkg.sv
// Shared constants and types for the message distributor.
// Direction encoding matches the decoder's dir fields: 0=N, 1=E, 2=S, 3=W.
package nx_msg_distributor_pkg;

  localparam int NX_DIRECTIONS = 4;

  typedef enum logic [1:0] {
    DIRX_NORTH = 2'd0,
    DIRX_EAST  = 2'd1,
    DIRX_SOUTH = 2'd2,
    DIRX_WEST  = 2'd3
  } nx_direction_t;

endpackage

// File: rtl/nx_msg_dist_slot.sv
// Single-entry holding register for one mesh direction.
// Optional feature macro: NX_DIST_PASSTHRU_EN. When it is defined, a slot that
// is draining this cycle also reports itself free, so that a load and a drain
// can happen on the same edge.
module nx_msg_dist_slot #(
  parameter int STREAM_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [STREAM_WIDTH-1:0] load_data_i,
  input  logic                    ready_i,
  output logic [STREAM_WIDTH-1:0] data_o,
  output logic                    valid_o,
  output logic                    free_o
);

  logic [STREAM_WIDTH-1:0] data_q;
  logic                    valid_q;

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef NX_DIST_PASSTHRU_EN
  // Draining slots count as free; this creates the ready_i -> free_o path.
  assign free_o = !valid_q || ready_i;
`else
  // Only an empty slot is free, keeping link ready off the source ready path.
  assign free_o = !valid_q;
`endif

  // Load wins over drain; data only moves on a load, so it holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/nx_msg_distributor.sv
// Merges the decoder bypass stream and the local emit stream into four
// per-direction holding slots, with round-robin arbitration when both
// sources target the same direction in the same cycle.
// Optional feature macro: NX_DIST_PASSTHRU_EN (handled inside each slot).
module nx_msg_distributor
  import nx_msg_distributor_pkg::*;
#(
  parameter int STREAM_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [STREAM_WIDTH-1:0]               bypass_data_i,
  input  logic [1:0]                            bypass_dir_i,
  input  logic                                  bypass_valid_i,
  output logic                                  bypass_ready_o,
  input  logic [STREAM_WIDTH-1:0]               emit_data_i,
  input  logic [1:0]                            emit_dir_i,
  input  logic                                  emit_valid_i,
  output logic                                  emit_ready_o,
  output logic [NX_DIRECTIONS*STREAM_WIDTH-1:0] dist_data_o,
  output logic [NX_DIRECTIONS-1:0]              dist_valid_o,
  input  logic [NX_DIRECTIONS-1:0]              dist_ready_i
);

  logic                    rr_q;
  logic [NX_DIRECTIONS-1:0] slot_free;
  logic [NX_DIRECTIONS-1:0] slot_load;
  logic [STREAM_WIDTH-1:0] slot_load_data [NX_DIRECTIONS];
  logic                    bypass_elig;
  logic                    emit_elig;
  logic                    collide;
  logic                    bypass_accept;
  logic                    emit_accept;

  // Arbitration: rr_q=0 prefers bypass, rr_q=1 prefers emit on a collision.
  always_comb begin
    bypass_elig   = bypass_valid_i && slot_free[bypass_dir_i];
    emit_elig     = emit_valid_i && slot_free[emit_dir_i];
    collide       = bypass_elig && emit_elig && (bypass_dir_i == emit_dir_i);
    bypass_accept = !rst_i && bypass_elig && !(collide && rr_q);
    emit_accept   = !rst_i && emit_elig && !(collide && !rr_q);
  end

  assign bypass_ready_o = bypass_accept;
  assign emit_ready_o   = emit_accept;

  // Steer each accepted message to its direction's slot.
  always_comb begin
    for (int d = 0; d < NX_DIRECTIONS; d++) begin
      slot_load[d]      = 1'b0;
      slot_load_data[d] = emit_data_i;
      if (bypass_accept && (bypass_dir_i == 2'(d))) begin
        slot_load[d]      = 1'b1;
        slot_load_data[d] = bypass_data_i;
      end else if (emit_accept && (emit_dir_i == 2'(d))) begin
        slot_load[d] = 1'b1;
      end
    end
  end

  // After a collision, point the preference at the source that lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (collide) begin
      rr_q <= !rr_q;
    end
  end

  for (genvar d = 0; d < NX_DIRECTIONS; d++) begin : g_slot
    nx_msg_dist_slot #(
      .STREAM_WIDTH(STREAM_WIDTH)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (slot_load[d]),
      .load_data_i(slot_load_data[d]),
      .ready_i    (dist_ready_i[d]),
      .data_o     (dist_data_o[d*STREAM_WIDTH +: STREAM_WIDTH]),
      .valid_o    (dist_valid_o[d]),
      .free_o     (slot_free[d])
    );
  end

endmodule
